// File: rtl/fault_response_analyzer.sv
// Fault response analyzer: compares faulty vs fault-free CUT outputs per pattern,
// sequences the fault sweep and accumulates detected/undetected fault counts.
//
// Ports:
//   clk, rst (async, active-low)   clock and reset
//   start                          begin sweep (accepted in IDLE/DONE only)
//   pat_valid, pat_last            pattern qualifier, final pattern of set
//   CUT_OP, FF_OP                  faulty / fault-free CUT outputs
//   FIL_INC, pat_restart           one-cycle pulses: next fault, pattern rewind
//   busy, done                     sweep in progress / sweep complete
//   fault_idx, det_cnt, undet_cnt  current fault and running coverage counts
//   last_det_pat                   pattern index of most recent detection
module fault_response_analyzer #(
   parameter int unsigned OUT_BITS   = 2,
   parameter int unsigned PAT_BITS   = 5,
   parameter int unsigned FAULT_BITS = 6,
   parameter int unsigned NUM_FAULTS = 22,
   parameter int unsigned SETTLE_CYC = 2,
   parameter bit          EARLY_EXIT = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  pat_valid,
   input  logic                  pat_last,
   input  logic [OUT_BITS-1:0]   CUT_OP,
   input  logic [OUT_BITS-1:0]   FF_OP,
   output logic                  FIL_INC,
   output logic                  pat_restart,
   output logic                  busy,
   output logic                  done,
   output logic [FAULT_BITS-1:0] fault_idx,
   output logic [FAULT_BITS-1:0] det_cnt,
   output logic [FAULT_BITS-1:0] undet_cnt,
   output logic [PAT_BITS-1:0]   last_det_pat
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RUN,
      S_ADV,
      S_SETTLE,
      S_DONE
   } state_t;

   localparam int unsigned SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

   state_t                state_q, state_d;
   logic [PAT_BITS-1:0]   pat_q, pat_d;
   logic                  hit_q, hit_d;
   logic [SW-1:0]         set_q, set_d;
   logic [FAULT_BITS-1:0] fidx_q, fidx_d;
   logic [FAULT_BITS-1:0] det_q, det_d;
   logic [FAULT_BITS-1:0] undet_q, undet_d;
   logic [PAT_BITS-1:0]   last_q, last_d;
   logic                  fil_q, fil_d;
   logic                  prs_q, prs_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  mis;

   assign mis = (CUT_OP != FF_OP);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         pat_q   <= '0;
         hit_q   <= 1'b0;
         set_q   <= '0;
         fidx_q  <= '0;
         det_q   <= '0;
         undet_q <= '0;
         last_q  <= '0;
         fil_q   <= 1'b0;
         prs_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pat_q   <= pat_d;
         hit_q   <= hit_d;
         set_q   <= set_d;
         fidx_q  <= fidx_d;
         det_q   <= det_d;
         undet_q <= undet_d;
         last_q  <= last_d;
         fil_q   <= fil_d;
         prs_q   <= prs_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pat_d   = pat_q;
      hit_d   = hit_q;
      set_d   = set_q;
      fidx_d  = fidx_q;
      det_d   = det_q;
      undet_d = undet_q;
      last_d  = last_q;
      fil_d   = 1'b0;
      prs_d   = 1'b0;
      unique case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d = S_RUN;
               pat_d   = '0;
               hit_d   = 1'b0;
               fidx_d  = '0;
               det_d   = '0;
               undet_d = '0;
               last_d  = '0;
               prs_d   = 1'b1;
            end
         end
         S_RUN: begin
            if (pat_valid) begin
               // Only the first mismatch of a fault records its pattern.
               if (mis && !hit_q) begin
                  hit_d  = 1'b1;
                  last_d = pat_q;
               end
               if ((mis && EARLY_EXIT) || pat_last) begin
                  state_d = S_ADV;
               end else begin
                  pat_d = pat_q + PAT_BITS'(1);
               end
            end
         end
         S_ADV: begin
            if (hit_q) begin
               det_d = det_q + FAULT_BITS'(1);
            end else begin
               undet_d = undet_q + FAULT_BITS'(1);
            end
            hit_d = 1'b0;
            pat_d = '0;
            if (fidx_q == FAULT_BITS'(NUM_FAULTS - 1)) begin
               state_d = S_DONE;
            end else begin
               fil_d   = 1'b1;
               prs_d   = 1'b1;
               fidx_d  = fidx_q + FAULT_BITS'(1);
               set_d   = '0;
               state_d = S_SETTLE;
            end
         end
         S_SETTLE: begin
            if (set_q == SW'(SETTLE_CYC - 1)) begin
               state_d = S_RUN;
            end else begin
               set_d = set_q + SW'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      busy_d = (state_d == S_RUN) || (state_d == S_ADV) ||
               (state_d == S_SETTLE);
      done_d = (state_d == S_DONE);
   end

   assign FIL_INC      = fil_q;
   assign pat_restart  = prs_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign fault_idx    = fidx_q;
   assign det_cnt      = det_q;
   assign undet_cnt    = undet_q;
   assign last_det_pat = last_q;

endmodule
